// File: rtl/bsg_parity_pkg.sv
// Package: bsg_parity_pkg
//   Shared definitions for the streaming parity checker:
//     - seg_width()      : width of one parity segment
//     - err_vec_t        : error-flag vector, sized for the largest supported
//                          segment count (users slice it to segments_p)
//     - max_segments_lp  : upper bound on segments_p
//     - max_count_lp     : saturation value of a default-width error counter
package bsg_parity_pkg;

    localparam int unsigned max_segments_lp          = 64;
    localparam int unsigned default_err_cnt_width_lp = 8;
    localparam int unsigned max_count_lp             = (1 << default_err_cnt_width_lp) - 1;

    typedef logic [max_segments_lp-1:0] err_vec_t;

    function automatic int unsigned seg_width(input int unsigned width_p,
                                              input int unsigned segments_p);
        return width_p / segments_p;
    endfunction

endpackage

// File: rtl/bsg_parity_seg_xor.sv
// Module: bsg_parity_seg_xor
//   Combinational segmented XOR reduction. Splits data_i into segments_p
//   equal segments and reduces each one to a single parity bit.
// Ports:
//   data_i  in   width_p     word to reduce; segment s = data_i[s*W +: W]
//   calc_o  out  segments_p  XOR of all bits of each segment
module bsg_parity_seg_xor
    import bsg_parity_pkg::*;
#(
    parameter int width_p    = 16,
    parameter int segments_p = 1
) (
    input  logic [width_p-1:0]    data_i,
    output logic [segments_p-1:0] calc_o
);

    localparam int unsigned seg_w_lp = seg_width(width_p, segments_p);

    for (genvar s = 0; s < segments_p; s++) begin : g_seg
        assign calc_o[s] = ^data_i[s*seg_w_lp +: seg_w_lp];
    end

endmodule

// File: rtl/bsg_parity_stream_checker.sv
// Module: bsg_parity_stream_checker
//   Streaming parity checker. Each accepted word is split into segments,
//   each segment is XOR-reduced and compared with its expected even-parity
//   bit; the word and its per-segment error flags are held in a single-entry
//   output register. A saturating counter tallies accepted words with any
//   error.
// Optional feature (macro BSG_PARITY_STICKY_EN):
//   defined   -> sticky_err_o sets on any counted error, holds until clear_i
//   undefined -> sticky_err_o is tied low, no flop
// Ports:
//   clk_i         in   1                clock
//   reset_n_i     in   1                asynchronous reset, active-low
//   v_i           in   1                input word valid
//   data_i        in   width_p          input word
//   parity_i      in   segments_p       expected parity bit per segment
//   ready_o       out  1                a word can be accepted this cycle
//   v_o           out  1                output register holds a word
//   data_o        out  width_p          registered word
//   err_o         out  segments_p       per-segment parity mismatch
//   yumi_i        in   1                downstream consumes the held word
//   clear_i       in   1                synchronous clear of counter/sticky
//   err_count_o   out  err_cnt_width_p  saturating count of bad words
//   sticky_err_o  out  1                sticky error flag
module bsg_parity_stream_checker
    import bsg_parity_pkg::*;
#(
    parameter int width_p         = 16,
    parameter int segments_p      = 1,
    parameter int err_cnt_width_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    input  logic [segments_p-1:0]      parity_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [segments_p-1:0]      err_o,
    input  logic                       yumi_i,
    input  logic                       clear_i,
    output logic [err_cnt_width_p-1:0] err_count_o,
    output logic                       sticky_err_o
);

    if (width_p % segments_p != 0) begin : g_bad_seg
        $error("width_p must be divisible by segments_p");
    end
    if (segments_p > max_segments_lp) begin : g_bad_nseg
        $error("segments_p exceeds max_segments_lp");
    end

    localparam logic [err_cnt_width_p-1:0] cnt_max_lp = '1;

    logic [segments_p-1:0]      calc;
    err_vec_t                   err_vec;
    logic                       accept;
    logic                       inc;

    logic                       v_d,    v_q;
    logic [width_p-1:0]         data_d, data_q;
    logic [segments_p-1:0]      err_d,  err_q;
    logic [err_cnt_width_p-1:0] cnt_d,  cnt_q;

    bsg_parity_seg_xor #(
        .width_p   (width_p),
        .segments_p(segments_p)
    ) u_seg_xor (
        .data_i(data_i),
        .calc_o(calc)
    );

    // Room exists when empty, or when the held word leaves this same cycle.
    assign ready_o = ~v_q | yumi_i;
    assign accept  = v_i & ready_o;

    always_comb begin
        err_vec                 = '0;
        err_vec[segments_p-1:0] = calc ^ parity_i;
        inc                     = accept & (|err_vec);

        v_d    = accept | (v_q & ~yumi_i);
        data_d = data_q;
        err_d  = err_q;
        if (accept) begin
            data_d = data_i;
            err_d  = err_vec[segments_p-1:0];
        end

        // A clear coinciding with a new error still counts that error.
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = inc ? err_cnt_width_p'(1) : '0;
        end else if (inc && (cnt_q != cnt_max_lp)) begin
            cnt_d = cnt_q + err_cnt_width_p'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
            err_q  <= '0;
            cnt_q  <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign v_o         = v_q;
    assign data_o      = data_q;
    assign err_o       = err_q;
    assign err_count_o = cnt_q;

`ifdef BSG_PARITY_STICKY_EN
    logic sticky_d, sticky_q;

    always_comb begin
        sticky_d = sticky_q;
        if (inc) begin
            sticky_d = 1'b1;
        end else if (clear_i) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_err_o = sticky_q;
`else
    assign sticky_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_parity_stream_checker.sv
module tb_bsg_parity_stream_checker;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b1;
    logic        v_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [1:0]  parity_i = '0;
    logic        yumi_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        ready_o, v_o, sticky_err_o;
    logic [15:0] data_o;
    logic [1:0]  err_o;
    logic [3:0]  err_count_o;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    bsg_parity_stream_checker #(
        .width_p(16), .segments_p(2), .err_cnt_width_p(4)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
        .parity_i(parity_i), .ready_o(ready_o), .v_o(v_o), .data_o(data_o),
        .err_o(err_o), .yumi_i(yumi_i), .clear_i(clear_i),
        .err_count_o(err_count_o), .sticky_err_o(sticky_err_o)
    );

    always #5 clk = ~clk;

    // Even parity of each byte, computed by counting ones.
    function automatic logic [1:0] gp(input logic [15:0] d);
        logic [1:0] r;
        r[1] = ($countones(d[15:8]) % 2) == 1;
        r[0] = ($countones(d[7:0]) % 2) == 1;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one-entry buffer with a plain integer saturating count.
    logic        m_v, m_sticky, last_ready;
    logic [15:0] m_data;
    logic [1:0]  m_err;
    int          m_cnt;

    always @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            m_v <= 1'b0; m_data <= '0; m_err <= '0; m_cnt <= 0;
            m_sticky <= 1'b0; last_ready <= 1'b1;
        end else begin
            automatic logic       rdy = !m_v || yumi_i;
            automatic logic       acc = v_i && rdy;
            automatic logic [1:0] e   = gp(data_i) ^ parity_i;
            automatic logic       bad = acc && (e != 2'b00);
            last_ready <= rdy;
            if (acc) begin
                m_data <= data_i;
                m_err  <= e;
            end
            m_v <= acc || (m_v && !yumi_i);
            if (clear_i) m_cnt <= bad ? 1 : 0;
            else if (bad) m_cnt <= (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
`ifdef BSG_PARITY_STICKY_EN
            if (bad) m_sticky <= 1'b1;
            else if (clear_i) m_sticky <= 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("v_o", 32'(v_o), 32'(m_v));
            check("data_o", 32'(data_o), 32'(m_data));
            check("err_o", 32'(err_o), 32'(m_err));
            check("err_count_o", 32'(err_count_o), 32'(m_cnt));
            check("sticky_err_o", 32'(sticky_err_o), 32'(m_sticky));
            check("ready_o", 32'(ready_o), 32'(!m_v || yumi_i));
        end
    end

    task automatic step(input logic v, input logic [15:0] d, input logic [1:0] p,
                        input logic y, input logic c);
        v_i = v; data_i = d; parity_i = p; yumi_i = y; clear_i = c;
        @(posedge clk); #1;
    endtask

    initial begin
        #1 reset_n_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n_i = 1'b1;
        chk_en = 1'b1;

        // Clean word
        step(1, 16'hA5A5, 2'b00, 0, 0);
        check("clean_v", 32'(v_o), 1);
        check("clean_data", 32'(data_o), 32'hA5A5);
        check("clean_err", 32'(err_o), 0);
        check("clean_cnt", 32'(err_count_o), 0);

        // Bad words, low then high segment
        step(1, 16'h0001, 2'b00, 1, 0);
        check("bad_lo_err", 32'(err_o), 32'h1);
        check("bad_lo_cnt", 32'(err_count_o), 1);
        step(1, 16'h0100, 2'b00, 1, 0);
        check("bad_hi_err", 32'(err_o), 32'h2);
        check("bad_hi_cnt", 32'(err_count_o), 2);

        // Backpressure
        step(1, 16'h1234, gp(16'h1234), 1, 0);
        check("bp_first", 32'(data_o), 32'h1234);
        v_i = 1; data_i = 16'h5678; parity_i = gp(16'h5678); yumi_i = 0;
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_ready_low", 32'(ready_o), 0);
            @(posedge clk); #1;
            check("bp_hold", 32'(data_o), 32'h1234);
        end
        yumi_i = 1;
        #1 check("bp_ready_high", 32'(ready_o), 1);
        @(posedge clk); #1;
        check("bp_second", 32'(data_o), 32'h5678);
        check("bp_second_v", 32'(v_o), 1);
        step(0, 16'h0000, 2'b00, 1, 0);
        check("drain_v", 32'(v_o), 0);
        check("drain_data", 32'(data_o), 32'h5678);
        check("bp_cnt", 32'(err_count_o), 2);

        // Saturation
        step(0, 16'h0000, 2'b00, 0, 1);
        check("clr_cnt", 32'(err_count_o), 0);
        for (int i = 0; i < 20; i++) step(1, 16'h0001, 2'b00, i > 0, 0);
        check("sat_cnt", 32'(err_count_o), 15);
`ifdef BSG_PARITY_STICKY_EN
        check("sticky_set", 32'(sticky_err_o), 1);
`else
        check("sticky_off", 32'(sticky_err_o), 0);
`endif
        step(1, 16'h0001, 2'b00, 1, 1);
        check("clr_inc_cnt", 32'(err_count_o), 1);
        for (int i = 0; i < 5; i++) step(1, 16'hA5A5, 2'b00, 1, 0);
`ifdef BSG_PARITY_STICKY_EN
        check("sticky_hold", 32'(sticky_err_o), 1);
`else
        check("sticky_off2", 32'(sticky_err_o), 0);
`endif
        step(0, 16'h0000, 2'b00, 1, 1);
        check("clr2_cnt", 32'(err_count_o), 0);
        check("clr2_sticky", 32'(sticky_err_o), 0);

        // Asynchronous reset mid-stream
        step(1, 16'h0001, 2'b00, 0, 0);
        check("pre_rst_cnt", 32'(err_count_o), 1);
        v_i = 1; data_i = 16'h0100; parity_i = 2'b00;
        #1 reset_n_i = 1'b0;
        #1;
        check("rst_v", 32'(v_o), 0);
        check("rst_cnt", 32'(err_count_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_err", 32'(err_o), 0);
        v_i = 0; yumi_i = 0; clear_i = 0;
        @(posedge clk); @(posedge clk); #1;
        reset_n_i = 1'b1;

        // Randomized traffic, source holds while stalled
        for (int i = 0; i < 3000; i++) begin
            if (!(v_i && !last_ready)) begin
                automatic logic [15:0] d = 16'($urandom);
                v_i = ($urandom_range(0, 3) != 0);
                data_i = d;
                parity_i = gp(d) ^ (($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            end
            yumi_i  = m_v && ($urandom_range(0, 3) != 0);
            clear_i = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
        end

        v_i = 0; yumi_i = 0; clear_i = 0;
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
